// File: rtl/led_matrix_scanner_pkg.sv
// led_matrix_pkg: colour codes, swap FSM states and code-to-lane decode shared by the scanner.
package led_matrix_pkg;
  localparam int DEF_CODE_W = 3;
  typedef logic [DEF_CODE_W-1:0] color_code_t;
  typedef enum logic [DEF_CODE_W-1:0] {
    C_OFF, C_RED, C_BLUE, C_WHITE, C_YELLOW, C_MAGENTA, C_CYAN, C_GREEN
  } color_e;
  typedef enum logic {IDLE, PENDING} swap_state_e;
  // {r,g,b} on-bits per code; anything above 7 is off
  localparam logic [2:0] RGB_LUT [8] = '{3'b000, 3'b100, 3'b001, 3'b111, 3'b110, 3'b101, 3'b011, 3'b010};
  function automatic logic [2:0] decode_rgb(input logic [7:0] code);
    return |code[7:3] ? 3'b000 : RGB_LUT[code[2:0]];
  endfunction
endpackage

// File: rtl/led_matrix_scanner_if.sv
// led_matrix_scanner_if: pixel-write and frame-swap bus between the game core and the scanner.
interface led_matrix_scanner_if #(parameter int ROWS = 8, COLS = 8, CODE_W = 3) ();
  logic wr_en;
  logic [$clog2(ROWS)-1:0] wr_row;
  logic [$clog2(COLS)-1:0] wr_col;
  logic [CODE_W-1:0] wr_code;
  logic swap_req;
  logic swap_ack;
  modport master(output wr_en, wr_row, wr_col, wr_code, swap_req, input swap_ack);
  modport slave(input wr_en, wr_row, wr_col, wr_code, swap_req, output swap_ack);
endinterface

// File: rtl/led_matrix_scanner_frame_buffer.sv
// matrix_frame_buffer: two-bank pixel store; writes go to the back bank, one row of the front bank is read.
module matrix_frame_buffer #(parameter int ROWS = 8, COLS = 8, CODE_W = 3) (
  input  logic clk,
  input  logic rst,
  input  logic wr_en,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [$clog2(COLS)-1:0] wr_col,
  input  logic [CODE_W-1:0] wr_code,
  input  logic swap,
  input  logic [$clog2(ROWS)-1:0] rd_row,
  output logic [COLS-1:0][CODE_W-1:0] rd_codes
);
  logic [1:0][ROWS-1:0][COLS-1:0][CODE_W-1:0] mem;
  logic front;
  logic in_range;
  assign in_range = int'(wr_row) < ROWS && int'(wr_col) < COLS;
  assign rd_codes = mem[front][rd_row];
  // write and bank flip both use the pre-swap select, so a swap-cycle write lands in the new front
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem <= '0;
      front <= 1'b0;
    end else begin
      if (wr_en && in_range) mem[~front][wr_row][wr_col] <= wr_code;
      if (swap) front <= ~front;
    end
  end
endmodule

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: row-scan RGB matrix driver with blanking, global PWM and tear-free frame swap.
module led_matrix_scanner import led_matrix_pkg::*; #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int CODE_W = 3,
  parameter int SLOT_CYC = 50000,
  parameter int BLANK_CYC = 16,
  parameter int BRIGHT_W = 4
) (
  input  logic clk,
  input  logic rst,
  led_matrix_scanner_if.slave bus,
  input  logic [BRIGHT_W-1:0] brightness,
  output logic frame_start,
  output logic [0:COLS-1] DATA_R,
  output logic [0:COLS-1] DATA_G,
  output logic [0:COLS-1] DATA_B,
  output logic [$clog2(ROWS)-1:0] S,
  output logic En
);
  localparam int RW = $clog2(ROWS);
  localparam int SW = $clog2(SLOT_CYC);
  logic [SW-1:0] slot_cnt;
  logic [RW-1:0] row;
  logic [BRIGHT_W-1:0] pwm_cnt, bright_q;
  swap_state_e st;
  logic [COLS-1:0][CODE_W-1:0] codes;
  logic slot_end, frame_end, do_swap, lit, duty;
  logic [0:COLS-1] r_n, g_n, b_n;
  logic [2:0] rgb;
  assign slot_end = slot_cnt == SW'(SLOT_CYC - 1);
  assign frame_end = slot_end && row == RW'(ROWS - 1);
  assign do_swap = frame_end && (st == PENDING || bus.swap_req);
  assign bus.swap_ack = do_swap;
  assign lit = int'(slot_cnt) >= BLANK_CYC;
  assign duty = pwm_cnt < bright_q || &bright_q;
  matrix_frame_buffer #(.ROWS(ROWS), .COLS(COLS), .CODE_W(CODE_W)) fb (
    .clk(clk),
    .rst(rst),
    .wr_en(bus.wr_en),
    .wr_row(bus.wr_row),
    .wr_col(bus.wr_col),
    .wr_code(bus.wr_code),
    .swap(do_swap),
    .rd_row(row),
    .rd_codes(codes)
  );
  always_comb begin
    r_n = '1;
    g_n = '1;
    b_n = '1;
    rgb = '0;
    for (int c = 0; c < COLS; c++) begin
      rgb = decode_rgb(8'(codes[c]));
      r_n[c] = ~(lit && duty && rgb[2]);
      g_n[c] = ~(lit && duty && rgb[1]);
      b_n[c] = ~(lit && duty && rgb[0]);
    end
  end
  // every output is registered from the same counter state, so S, En and DATA_* move together
  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_cnt <= '0;
      row <= '0;
      pwm_cnt <= '0;
      bright_q <= brightness;
      st <= IDLE;
      S <= '0;
      En <= 1'b0;
      frame_start <= 1'b0;
      DATA_R <= '1;
      DATA_G <= '1;
      DATA_B <= '1;
    end else begin
      slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
      if (slot_end) begin
        row <= row == RW'(ROWS - 1) ? '0 : row + 1'b1;
        bright_q <= brightness;
      end
      pwm_cnt <= pwm_cnt + 1'b1;
      st <= do_swap ? IDLE : bus.swap_req ? PENDING : st;
      S <= row;
      En <= lit;
      frame_start <= slot_cnt == '0 && row == '0;
      DATA_R <= r_n;
      DATA_G <= g_n;
      DATA_B <= b_n;
    end
  end
endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner: directed vector bench for the row-scan matrix driver.
module tb_led_matrix_scanner;
  localparam int ROWS = 8, COLS = 8, CODE_W = 3, SLOT = 20, BLANK = 2, BW = 4;
  localparam int FRAME = ROWS * SLOT;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  led_matrix_scanner_if #(.ROWS(ROWS), .COLS(COLS), .CODE_W(CODE_W)) bus ();
  logic [BW-1:0] brightness;
  logic frame_start, en;
  logic [0:COLS-1] dr, dg, db;
  logic [2:0] s;
  led_matrix_scanner #(.ROWS(ROWS), .COLS(COLS), .CODE_W(CODE_W), .SLOT_CYC(SLOT),
                       .BLANK_CYC(BLANK), .BRIGHT_W(BW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .brightness(brightness), .frame_start(frame_start),
    .DATA_R(dr), .DATA_G(dg), .DATA_B(db), .S(s), .En(en)
  );
  led_matrix_scanner_if #(.ROWS(5), .COLS(6), .CODE_W(CODE_W)) bus2 ();
  logic [BW-1:0] bright2 = 4'hF;
  logic fs2, en2;
  logic [0:5] dr2, dg2, db2;
  logic [2:0] s2;
  led_matrix_scanner #(.ROWS(5), .COLS(6), .CODE_W(CODE_W), .SLOT_CYC(8),
                       .BLANK_CYC(2), .BRIGHT_W(BW)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave), .brightness(bright2), .frame_start(fs2),
    .DATA_R(dr2), .DATA_G(dg2), .DATA_B(db2), .S(s2), .En(en2)
  );
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [2:0] row;
    logic [2:0] col;
    logic [2:0] code;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } vec_t;
  vec_t vt [8];
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    bus.wr_en = 1'b0;
    bus.swap_req = 1'b0;
    bus2.wr_en = 1'b0;
    bus2.swap_req = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask
  task automatic write_px(input logic [2:0] r, input logic [2:0] c, input logic [2:0] code);
    bus.wr_en = 1'b1;
    bus.wr_row = r;
    bus.wr_col = c;
    bus.wr_code = code;
    tick();
    bus.wr_en = 1'b0;
  endtask
  task automatic write_px2(input logic [2:0] r, input logic [2:0] c, input logic [2:0] code);
    bus2.wr_en = 1'b1;
    bus2.wr_row = r;
    bus2.wr_col = c;
    bus2.wr_code = code;
    tick();
    bus2.wr_en = 1'b0;
  endtask
  task automatic pulse_swap();
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
  endtask
  task automatic wait_swap();
    int i;
    for (i = 0; i < 2 * FRAME; i++) begin
      if (bus.swap_ack) break;
      tick();
    end
    check("ack_seen", 32'(i < 2 * FRAME), 1);
    tick();
    tick();
    check("ack_to_frame_start", 32'(frame_start), 1);
  endtask
  task automatic wait_fs();
    int i;
    for (i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (frame_start) break;
    end
    check("fs_seen", 32'(i < 2 * FRAME), 1);
  endtask
  task automatic sample_row(input logic [2:0] r);
    int i;
    for (i = 0; i < 2 * FRAME; i++) begin
      if (s == r && en) break;
      tick();
    end
    check("row_reached", 32'(i < 2 * FRAME), 1);
  endtask
  initial begin
    int n, nb, i;
    bus.wr_en = 1'b0; bus.wr_row = '0; bus.wr_col = '0; bus.wr_code = '0; bus.swap_req = 1'b0;
    bus2.wr_en = 1'b0; bus2.wr_row = '0; bus2.wr_col = '0; bus2.wr_code = '0; bus2.swap_req = 1'b0;
    brightness = 4'hF;
    vt[0] = '{3'd2, 3'd5, 3'd3, 8'b11111011, 8'b11111011, 8'b11111011};
    vt[1] = '{3'd0, 3'd0, 3'd1, 8'h7F, 8'hFF, 8'hFF};
    vt[2] = '{3'd7, 3'd7, 3'd2, 8'hFF, 8'hFF, 8'hFE};
    vt[3] = '{3'd3, 3'd1, 3'd4, 8'hBF, 8'hBF, 8'hFF};
    vt[4] = '{3'd4, 3'd2, 3'd5, 8'hDF, 8'hFF, 8'hDF};
    vt[5] = '{3'd5, 3'd3, 3'd6, 8'hFF, 8'hEF, 8'hEF};
    vt[6] = '{3'd6, 3'd4, 3'd7, 8'hFF, 8'hF7, 8'hFF};
    vt[7] = '{3'd1, 3'd6, 3'd0, 8'hFF, 8'hFF, 8'hFF};
    tick();
    // single-pixel vectors: pixel shows in its row after swap, the next row stays dark
    foreach (vt[k]) begin
      do_reset();
      write_px(vt[k].row, vt[k].col, vt[k].code);
      pulse_swap();
      wait_swap();
      sample_row(vt[k].row);
      check($sformatf("vec%0d_r", k), 32'(dr), 32'(vt[k].r));
      check($sformatf("vec%0d_g", k), 32'(dg), 32'(vt[k].g));
      check($sformatf("vec%0d_b", k), 32'(db), 32'(vt[k].b));
      sample_row(vt[k].row + 3'd1);
      check($sformatf("vec%0d_other_row", k), {dr, dg, db}, 24'hFFFFFF);
    end
    // code sweep across row 0
    do_reset();
    for (int c = 0; c < 8; c++) write_px(3'd0, 3'(c), 3'(c));
    pulse_swap();
    wait_swap();
    sample_row(3'd0);
    check("sweep_r", 32'(dr), 8'hA3);
    check("sweep_g", 32'(dg), 8'hE4);
    check("sweep_b", 32'(db), 8'hC9);
    // PWM duty
    brightness = 4'd4;
    do_reset();
    write_px(3'd0, 3'd0, 3'd1);
    pulse_swap();
    wait_swap();
    sample_row(3'd0);
    n = 0;
    for (int k = 0; k < 16; k++) begin n += int'(!dr[0]); tick(); end
    check("pwm_4_of_16", n, 4);
    brightness = 4'd0;
    wait_fs();
    sample_row(3'd0);
    n = 0;
    for (int k = 0; k < 16; k++) begin n += int'(!dr[0]); tick(); end
    check("pwm_0_dark", n, 0);
    brightness = 4'hF;
    wait_fs();
    sample_row(3'd0);
    n = 0;
    for (int k = 0; k < 16; k++) begin n += int'(!dr[0]); tick(); end
    check("pwm_full_on", n, 16);
    // two requests in one frame, write on the swap cycle
    do_reset();
    write_px(3'd4, 3'd4, 3'd7);
    pulse_swap();
    repeat (40) tick();
    pulse_swap();
    n = 0;
    for (int k = 0; k < 2 * FRAME + 20; k++) begin
      if (bus.swap_ack) begin
        n++;
        if (n == 1) begin
          bus.wr_en = 1'b1; bus.wr_row = 3'd6; bus.wr_col = 3'd1; bus.wr_code = 3'd1;
        end
      end
      tick();
      bus.wr_en = 1'b0;
    end
    check("single_ack", n, 1);
    sample_row(3'd6);
    check("swap_cycle_write", 32'(dr), 8'hBF);
    sample_row(3'd4);
    check("pre_swap_pixel", 32'(dg), 8'hF7);
    // back-buffer writes stay hidden until the swap; old front returns unchanged
    write_px(3'd0, 3'd0, 3'd3);
    wait_fs();
    sample_row(3'd0);
    check("no_tear", {dr, dg, db}, 24'hFFFFFF);
    pulse_swap();
    wait_swap();
    sample_row(3'd0);
    check("after_swap_r", 32'(dr), 8'h7F);
    check("after_swap_b", 32'(db), 8'h7F);
    sample_row(3'd6);
    check("old_pixel_gone", {dr, dg, db}, 24'hFFFFFF);
    pulse_swap();
    wait_swap();
    sample_row(3'd6);
    check("old_front_back", 32'(dr), 8'hBF);
    // reset in the middle of a lit slot with a swap pending
    pulse_swap();
    sample_row(3'd3);
    repeat (5) tick();
    rst = 1'b0;
    tick();
    check("rst_S", 32'(s), 0);
    check("rst_En", 32'(en), 0);
    check("rst_data", {dr, dg, db}, 24'hFFFFFF);
    check("rst_fs", 32'(frame_start), 0);
    rst = 1'b1;
    tick();
    check("rel_fs", 32'(frame_start), 1);
    check("rel_S", 32'(s), 0);
    check("rel_En", 32'(en), 0);
    nb = 0;
    n = 0;
    for (int k = 0; k < FRAME; k++) begin
      nb += int'(!en);
      n += int'(bus.swap_ack);
      tick();
    end
    check("blank_cycles", nb, ROWS * BLANK);
    check("frame_period", 32'(frame_start), 1);
    check("pending_cleared", n, 0);
    // out-of-range writes on a 5x6 instance
    do_reset();
    write_px2(3'd5, 3'd0, 3'd3);
    write_px2(3'd7, 3'd2, 3'd3);
    write_px2(3'd0, 3'd6, 3'd3);
    write_px2(3'd1, 3'd7, 3'd3);
    bus2.swap_req = 1'b1;
    tick();
    bus2.swap_req = 1'b0;
    for (i = 0; i < 100; i++) begin
      if (bus2.swap_ack) break;
      tick();
    end
    check("oor_ack", 32'(i < 100), 1);
    tick();
    tick();
    n = 0;
    for (int k = 0; k < 45; k++) begin
      n += int'(!(&{dr2, dg2, db2}));
      tick();
    end
    check("oor_ignored", n, 0);
    write_px2(3'd4, 3'd5, 3'd3);
    bus2.swap_req = 1'b1;
    tick();
    bus2.swap_req = 1'b0;
    for (i = 0; i < 100; i++) begin
      if (bus2.swap_ack) break;
      tick();
    end
    check("inr_ack", 32'(i < 100), 1);
    tick();
    tick();
    for (i = 0; i < 100; i++) begin
      if (s2 == 3'd4 && en2) break;
      tick();
    end
    check("inr_row", 32'(i < 100), 1);
    check("inr_pixel", 32'(dr2), 6'h3E);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
